// File: rtl/regfile_dump_pkg.sv
// Shared constants for the register-file dump engine: sizing and FSM state codes.
package regfile_dump_pkg;

  localparam int unsigned REG_COUNT = 16;
  localparam int unsigned ADDR_W    = $clog2(REG_COUNT);
  localparam int unsigned ST_W      = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_LOAD = 2'd1;
  localparam logic [ST_W-1:0] ST_SEND = 2'd2;
  localparam logic [ST_W-1:0] ST_DONE = 2'd3;

  // Register index increment; wraps from the top entry back to 0.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/regfile_dump_out_reg.sv
// Output holding register for {data, index, last}; loads on enable, clears on reset.
module dump_out_reg #(
  parameter int unsigned WIDTH = 37
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/regfile_dump.sv
// Debug read-out engine: walks a wrapping range of register indices through a
// spare read port and streams {data, index, last} over a valid/ready channel.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic              clock_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] first_addr_i,
  input  logic [ADDR_W-1:0] last_addr_i,
  output logic [ADDR_W-1:0] rf_addr_o,
  input  logic [W-1:0]      rf_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [W-1:0]      out_data_o,
  output logic [ADDR_W-1:0] out_index_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned OUT_W = W + ADDR_W + 1;

  logic [ST_W-1:0]   state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] lim_q, lim_d;
  logic              valid_q, valid_d;
  logic              busy_q;
  logic              done_q, done_d;
  logic              load_c;
  logic              hs_c;
  logic [ADDR_W-1:0] rf_addr_c;
  logic [OUT_W-1:0]  out_bus;

  assign hs_c = valid_q & out_ready_i;

  // Next state, pointer advance and the read-port address mux.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    lim_d     = lim_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    load_c    = 1'b0;
    rf_addr_c = cur_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          cur_d   = first_addr_i;
          lim_d   = last_addr_i;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_c  = 1'b1;
        valid_d = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (hs_c) begin
          if (!out_last_o) begin
            // Prefetch the next word in the handshake cycle for 1 word/cycle.
            rf_addr_c = addr_inc(cur_q);
            cur_d     = addr_inc(cur_q);
            load_c    = 1'b1;
          end else begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over any handshake in the same cycle.
    if (abort_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      done_d  = 1'b0;
      load_c  = 1'b0;
    end
  end

  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      lim_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      lim_q   <= lim_d;
      valid_q <= valid_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
    end
  end

  dump_out_reg #(
    .WIDTH (OUT_W)
  ) u_out_reg (
    .clk_i  (clock_i),
    .rst_ni (rst_ni),
    .load_i (load_c),
    .d_i    ({rf_data_i, rf_addr_c, (rf_addr_c == lim_q)}),
    .q_o    (out_bus)
  );

  assign rf_addr_o   = rf_addr_c;
  assign out_data_o  = out_bus[OUT_W-1 -: W];
  assign out_index_o = out_bus[ADDR_W:1];
  assign out_last_o  = out_bus[0];
  assign out_valid_o = valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
